// File: rtl/wired_pkg.sv
// ---------------------------------------------------------------------------
// wired_pkg : shared types and constants for branch resolution / BPU update
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wired_pkg;

    localparam logic [1:0] TARGET_NONE = 2'd0;
    localparam logic [1:0] TARGET_CALL = 2'd1;
    localparam logic [1:0] TARGET_RET  = 2'd2;
    localparam logic [1:0] TARGET_IMM  = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  typ;
        logic        miss;
    } bpu_upd_t;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } rsv_state_e;

    function automatic logic is_ctrl(input logic [1:0] typ);
        return (typ == TARGET_CALL) || (typ == TARGET_RET) || (typ == TARGET_IMM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wired_bpu_upd_fifo.sv
// ---------------------------------------------------------------------------
// wired_bpu_upd_fifo : UPD_DEPTH-entry queue of predictor training records
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wired_bpu_upd_fifo
    import wired_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_valid_i,
    input  bpu_upd_t push_data_i,
    output logic     full_o,
    output logic     pop_valid_o,
    input  logic     pop_ready_i,
    output bpu_upd_t pop_data_o
);

    localparam int AW = $clog2(UPD_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    bpu_upd_t    mem_q [UPD_DEPTH];
    bpu_upd_t    mem_d [UPD_DEPTH];
    logic        empty;
    logic        do_push;
    logic        do_pop;

    always_comb begin
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push_valid_i && !full_o;
        do_pop   = !empty && pop_ready_i;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    assign pop_valid_o = !empty;
    assign pop_data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wired_branch_resolve.sv
// ---------------------------------------------------------------------------
// wired_branch_resolve : execute-stage branch check, squash/redirect, BPU update
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wired_branch_resolve
    import wired_pkg::*;
#(
    parameter int UPD_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    output logic             ex_ready_o,
    input  logic [31:0]      ex_pc_i,
    input  logic [1:0]       ex_type_i,
    input  logic             ex_jump_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [31:0]      ex_pred_target_i,
    input  logic             flush_i,
    output logic             squash_o,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [31:0]      redirect_pc_o,
    output logic             upd_valid_o,
    input  logic             upd_ready_i,
    output logic [31:0]      upd_pc_o,
    output logic [31:0]      upd_target_o,
    output logic             upd_taken_o,
    output logic [1:0]       upd_type_o,
    output logic             upd_miss_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    rsv_state_e       state_q, state_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        fifo_full;
    logic        beat;
    logic        wrong_path;
    logic        miss;
    logic        push;
    logic        take_redir;
    logic [31:0] next_pc;
    bpu_upd_t    push_rec;
    bpu_upd_t    head_rec;

    always_comb begin
        wrong_path = (state_q == ST_REDIRECT);
        // While redirecting every beat is wrong-path, so it is sunk regardless of queue space.
        ex_ready_o = wrong_path || !(fifo_full && (ex_type_i != TARGET_NONE));
        beat       = ex_valid_i && ex_ready_o;
        next_pc    = ex_jump_i ? ex_target_i : (ex_pc_i + 32'd4);
        miss       = (ex_pred_taken_i != ex_jump_i) ||
                     (ex_jump_i && (ex_pred_target_i != ex_target_i));
        push       = beat && !wrong_path && is_ctrl(ex_type_i);
        take_redir = beat && !wrong_path && miss && !flush_i;

        push_rec.pc     = ex_pc_i;
        push_rec.target = ex_target_i;
        push_rec.taken  = ex_jump_i;
        push_rec.typ    = ex_type_i;
        push_rec.miss   = miss;

        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take_redir) begin
                    state_d    = ST_REDIRECT;
                    redir_pc_d = next_pc;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_REDIRECT: begin
                if (flush_i || redirect_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            redir_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    wired_bpu_upd_fifo #(
        .UPD_DEPTH(UPD_DEPTH)
    ) u_upd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid_i(push),
        .push_data_i (push_rec),
        .full_o      (fifo_full),
        .pop_valid_o (upd_valid_o),
        .pop_ready_i (upd_ready_i),
        .pop_data_o  (head_rec)
    );

    assign squash_o         = take_redir;
    assign redirect_valid_o = (state_q == ST_REDIRECT);
    assign redirect_pc_o    = redir_pc_q;
    assign mispred_cnt_o    = cnt_q;
    assign upd_pc_o         = head_rec.pc;
    assign upd_target_o     = head_rec.target;
    assign upd_taken_o      = head_rec.taken;
    assign upd_type_o       = head_rec.typ;
    assign upd_miss_o       = head_rec.miss;

endmodule

`default_nettype wire

// File: tb/tb_wired_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_wired_branch_resolve : vector table, directed corners and random run vs model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wired_branch_resolve;
    import wired_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_jump, ex_pred_taken, flush, redirect_ready, upd_ready;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic [1:0]  ex_type;

    logic        ex_ready, squash, rv, upd_valid, upd_taken, upd_miss;
    logic [31:0] rpc, upd_pc, upd_target, cnt;
    logic [1:0]  upd_type;

    logic        s_ex_ready, s_squash, s_rv, s_upd_valid, s_upd_taken, s_upd_miss;
    logic [31:0] s_rpc, s_upd_pc, s_upd_target;
    logic [1:0]  s_upd_type, s_cnt;

    always #5 clk = ~clk;

    wired_branch_resolve #(.UPD_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
        .ex_pc_i(ex_pc), .ex_type_i(ex_type), .ex_jump_i(ex_jump), .ex_target_i(ex_target),
        .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target), .flush_i(flush),
        .squash_o(squash), .redirect_valid_o(rv), .redirect_ready_i(redirect_ready),
        .redirect_pc_o(rpc), .upd_valid_o(upd_valid), .upd_ready_i(upd_ready),
        .upd_pc_o(upd_pc), .upd_target_o(upd_target), .upd_taken_o(upd_taken),
        .upd_type_o(upd_type), .upd_miss_o(upd_miss), .mispred_cnt_o(cnt)
    );

    // Narrow counter instance exercises saturation within a short run.
    wired_branch_resolve #(.UPD_DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(s_ex_ready),
        .ex_pc_i(ex_pc), .ex_type_i(ex_type), .ex_jump_i(ex_jump), .ex_target_i(ex_target),
        .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target), .flush_i(flush),
        .squash_o(s_squash), .redirect_valid_o(s_rv), .redirect_ready_i(redirect_ready),
        .redirect_pc_o(s_rpc), .upd_valid_o(s_upd_valid), .upd_ready_i(upd_ready),
        .upd_pc_o(s_upd_pc), .upd_target_o(s_upd_target), .upd_taken_o(s_upd_taken),
        .upd_type_o(s_upd_type), .upd_miss_o(s_upd_miss), .mispred_cnt_o(s_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: redirect flag/pc, miss count, queue of training records.
    bit          m_redir;
    logic [31:0] m_rpc;
    longint      m_cnt;
    bpu_upd_t    m_q[$];

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [1:0]  typ;
        logic        j;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        fl, rr, ur;
        logic        e_rdy, e_sq, e_rv;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] typ,
                         input logic j, input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ptgt, input logic fl, input logic rr, input logic ur);
        ex_valid = v; ex_pc = pc; ex_type = typ; ex_jump = j; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptgt; flush = fl;
        redirect_ready = rr; upd_ready = ur;
        #4;
    endtask

    task automatic model_reset();
        m_redir = 1'b0; m_rpc = '0; m_cnt = 0; m_q.delete();
    endtask

    // Compare all outputs against the model, advance the model across the edge.
    task automatic step();
        bit          rdy, acc, mis, sq;
        logic [31:0] nxt;
        rdy = m_redir || !((m_q.size() == DEPTH) && (ex_type != 2'd0));
        acc = ex_valid && rdy;
        mis = (ex_pred_taken != ex_jump) || (ex_jump && (ex_pred_target != ex_target));
        nxt = ex_jump ? ex_target : ex_pc + 32'd4;
        sq  = acc && !m_redir && mis && !flush;
        chk("ex_ready", {63'd0, ex_ready}, {63'd0, rdy});
        chk("squash", {63'd0, squash}, {63'd0, sq});
        chk("sat_squash", {63'd0, s_squash}, {63'd0, sq});
        chk("redirect_valid", {63'd0, rv}, {63'd0, m_redir});
        chk("sat_redirect_valid", {63'd0, s_rv}, {63'd0, m_redir});
        chk("redirect_pc", {32'd0, rpc}, {32'd0, m_rpc});
        chk("upd_valid", {63'd0, upd_valid}, {63'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("upd_pc", {32'd0, upd_pc}, {32'd0, m_q[0].pc});
            chk("upd_target", {32'd0, upd_target}, {32'd0, m_q[0].target});
            chk("upd_taken", {63'd0, upd_taken}, {63'd0, m_q[0].taken});
            chk("upd_type", {62'd0, upd_type}, {62'd0, m_q[0].typ});
            chk("upd_miss", {63'd0, upd_miss}, {63'd0, m_q[0].miss});
        end
        chk("mispred_cnt", {32'd0, cnt}, m_cnt);
        chk("sat_cnt", {62'd0, s_cnt}, (m_cnt > 3) ? 64'd3 : m_cnt);

        if ((m_q.size() != 0) && upd_ready) void'(m_q.pop_front());
        if (acc && !m_redir && (ex_type != 2'd0))
            m_q.push_back('{pc: ex_pc, target: ex_target, taken: ex_jump, typ: ex_type, miss: mis});
        if (m_redir) begin
            if (flush || redirect_ready) m_redir = 1'b0;
        end else if (sq) begin
            m_redir = 1'b1;
            m_rpc   = nxt;
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [1:0] typ,
                                input logic j, input logic [31:0] tgt, input logic pt,
                                input logic [31:0] ptgt, input logic rr,
                                input logic e_rdy, input logic e_sq, input logic e_rv,
                                input logic [31:0] e_cnt);
        vec_t r;
        r.v = v; r.pc = pc; r.typ = typ; r.j = j; r.tgt = tgt; r.pt = pt; r.ptgt = ptgt;
        r.fl = 1'b0; r.rr = rr; r.ur = 1'b0;
        r.e_rdy = e_rdy; r.e_sq = e_sq; r.e_rv = e_rv; r.e_cnt = e_cnt;
        return r;
    endfunction

    initial begin
        tbl[0] = mk(1, 32'h1000, 2'd3, 1, 32'h2000, 1, 32'h2000, 0, 1, 0, 0, 0);
        tbl[1] = mk(1, 32'h1000, 2'd3, 0, 32'h1234, 1, 32'h2000, 0, 1, 1, 0, 0);
        tbl[2] = mk(0, 32'h0,    2'd0, 0, 32'h0,    0, 32'h0,    0, 1, 0, 1, 1);
        tbl[3] = mk(0, 32'h0,    2'd0, 0, 32'h0,    0, 32'h0,    0, 1, 0, 1, 1);
        tbl[4] = mk(0, 32'h0,    2'd0, 0, 32'h0,    0, 32'h0,    0, 1, 0, 1, 1);
        tbl[5] = mk(0, 32'h0,    2'd0, 0, 32'h0,    0, 32'h0,    1, 1, 0, 1, 1);
        tbl[6] = mk(1, 32'h2000, 2'd2, 1, 32'h3000, 1, 32'h3004, 0, 1, 1, 0, 1);
        tbl[7] = mk(1, 32'h4000, 2'd3, 0, 32'h0,    1, 32'h0,    0, 1, 0, 1, 2);
        tbl[8] = mk(1, 32'h4010, 2'd1, 1, 32'h5000, 0, 32'h0,    0, 1, 0, 1, 2);
        tbl[9] = mk(0, 32'h0,    2'd0, 0, 32'h0,    0, 32'h0,    1, 1, 0, 1, 2);

        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_squash", {63'd0, squash}, 64'd0);
        chk("rst_redirect_valid", {63'd0, rv}, 64'd0);
        chk("rst_redirect_pc", {32'd0, rpc}, 64'd0);
        chk("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
        chk("rst_cnt", {32'd0, cnt}, 64'd0);
        step();

        // Tests 1-3 as a vector table.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].typ, tbl[i].j, tbl[i].tgt, tbl[i].pt,
                  tbl[i].ptgt, tbl[i].fl, tbl[i].rr, tbl[i].ur);
            chk($sformatf("tbl%0d_ready", i), {63'd0, ex_ready}, {63'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_squash", i), {63'd0, squash}, {63'd0, tbl[i].e_sq});
            chk($sformatf("tbl%0d_rv", i), {63'd0, rv}, {63'd0, tbl[i].e_rv});
            chk($sformatf("tbl%0d_cnt", i), {32'd0, cnt}, {32'd0, tbl[i].e_cnt});
            if (tbl[i].e_rv && (i < 6)) chk($sformatf("tbl%0d_rpc", i), {32'd0, rpc}, 64'h1004);
            if (tbl[i].e_rv && (i >= 7)) chk($sformatf("tbl%0d_rpc", i), {32'd0, rpc}, 64'h3000);
            step();
        end

        // Test 4: mispredict with flush pushes but does not redirect (queue becomes full).
        drive(1, 32'h6000, 2'd3, 0, 32'h0, 1, 32'h0, 1, 0, 0);
        chk("flush_beat_squash", {63'd0, squash}, 64'd0);
        step();
        drive(1, 32'h6100, 2'd0, 0, 32'h0, 1, 32'h0, 0, 0, 0);
        chk("flush_after_rv", {63'd0, rv}, 64'd0);
        chk("flush_after_cnt", {32'd0, cnt}, 64'd2);
        chk("full_type0_ready", {63'd0, ex_ready}, 64'd1);
        chk("full_type0_squash", {63'd0, squash}, 64'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("pre_flush_rv", {63'd0, rv}, 64'd1);
        step();
        drive(1, 32'h6200, 2'd0, 0, 32'h0, 1, 32'h0, 0, 0, 0);
        chk("post_flush_rv", {63'd0, rv}, 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_rdy_rv", {63'd0, rv}, 64'd0);
        chk("sat_cnt_hold", {62'd0, s_cnt}, 64'd3);
        step();

        // Test 5: drain, then fill past depth under upd_ready=0.
        repeat (DEPTH) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h7000 + 32'(i * 4), 2'd3, 1, 32'h8000 + 32'(i * 16), 1,
                  32'h8000 + 32'(i * 16), 0, 0, 0);
            step();
        end
        drive(1, 32'h7010, 2'd3, 1, 32'h8040, 1, 32'h8040, 0, 0, 0);
        chk("full_ready", {63'd0, ex_ready}, 64'd0);
        step();
        drive(1, 32'h7020, 2'd0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        chk("full_type0_ready2", {63'd0, ex_ready}, 64'd1);
        step();
        drive(1, 32'h7010, 2'd3, 1, 32'h8040, 1, 32'h8040, 0, 0, 1);
        chk("full_poppush_ready", {63'd0, ex_ready}, 64'd0);
        step();
        drive(1, 32'h7010, 2'd3, 1, 32'h8040, 1, 32'h8040, 0, 0, 1);
        chk("after_pop_ready", {63'd0, ex_ready}, 64'd1);
        step();
        repeat (DEPTH + 1) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            step();
        end

        // Test 6: sequential pc wraps to zero.
        drive(1, 32'hFFFF_FFFC, 2'd3, 0, 32'h0, 1, 32'h0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("wrap_rpc", {32'd0, rpc}, 64'h0);
        chk("wrap_sat_cnt", {62'd0, s_cnt}, 64'd3);
        step();

        // Reset asserted mid-redirect with records queued.
        drive(1, 32'h9000, 2'd3, 0, 32'h0, 1, 32'h0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rv", {63'd0, rv}, 64'd0);
        chk("midrst_upd_valid", {63'd0, upd_valid}, 64'd0);
        chk("midrst_cnt", {32'd0, cnt}, 64'd0);
        chk("midrst_rpc", {32'd0, rpc}, 64'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random run against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc, tgt;
            pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} >> 2 << 2;
            tgt = $urandom();
            drive($urandom_range(0, 9) < 7, pc, 2'($urandom_range(0, 3)), 1'($urandom()), tgt,
                  1'($urandom()), ($urandom_range(0, 2) != 0) ? tgt : $urandom(),
                  $urandom_range(0, 15) == 0, 1'($urandom()), $urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
